// File: rtl/mul_acc_pkg.sv
// Shared types and constants for the multiply-accumulate result stage.
package mul_acc_pkg;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX = '1;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    // Returns {ovf, sum} for the default widths; sum clamps to ACC_MAX on carry.
    function automatic logic [ACC_W_DEF:0] sat_add(input logic [ACC_W_DEF-1:0]  acc,
                                                   input logic [PROD_W_DEF-1:0] add);
        logic [ACC_W_DEF:0] wide;
        wide = {1'b0, acc} + {{(ACC_W_DEF + 1 - PROD_W_DEF){1'b0}}, add};
        return wide[ACC_W_DEF] ? {1'b1, ACC_MAX} : wide;
    endfunction

endpackage

// File: rtl/mul_acc_if.sv
// Product stream in, frame result out; master drives beats and out_ready.
interface mul_acc_if
    import mul_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );

endinterface

// File: rtl/mul_acc_sat_adder.sv
// Combinational saturating adder: product into accumulator, carry clamps to all-ones.
module mul_acc_sat_adder #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] add,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam int WIDE_W = ACC_W + 1;

    logic [ACC_W:0] wide;

    always_comb begin
        wide = {1'b0, acc} + WIDE_W'(add);
        ovf  = wide[ACC_W];
        sum  = ovf ? '1 : wide[ACC_W-1:0];
    end

endmodule

// File: rtl/mul_acc_stage.sv
// Frames a product stream into a saturating sum, beat count and overflow flag,
// holding each result on a valid/ready output until accepted.
module mul_acc_stage
    import mul_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clr,
    mul_acc_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, add_sum, f_acc;
    logic [CNT_W-1:0] cnt, f_cnt;
    logic             ovf, add_ovf, f_ovf;
    logic             beat, abort;
    logic [ACC_W-1:0] res_data;
    logic [CNT_W-1:0] res_count;
    logic             res_ovf;

    mul_acc_sat_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc (acc),
        .add (bus.in_data),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        bus.in_ready  = (state != DRAIN);
        bus.out_valid = (state == DRAIN);
        abort         = clr && (state != DRAIN);
        // A beat offered alongside clr is consumed but never accumulated.
        beat          = bus.in_valid && bus.in_ready && !clr;
        case (state)
            IDLE, ACCUM: begin
                if (abort)     state_n = IDLE;
                else if (beat) state_n = bus.in_last ? DRAIN : ACCUM;
            end
            DRAIN:   if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        if (state == IDLE) begin
            f_acc = ACC_W'(bus.in_data);
            f_cnt = CNT_W'(1);
            f_ovf = 1'b0;
        end else begin
            f_acc = add_sum;
            f_cnt = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
            f_ovf = ovf | add_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            res_data  <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else if (abort) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (beat) begin
            acc <= f_acc;
            cnt <= f_cnt;
            ovf <= f_ovf;
            if (bus.in_last) begin
                res_data  <= f_acc;
                res_count <= f_cnt;
                res_ovf   <= f_ovf;
            end
        end
    end

    assign bus.out_data  = res_data;
    assign bus.out_count = res_count;
    assign bus.out_ovf   = res_ovf;

endmodule
